store_buffer: RTL and testbench

Four-entry store FIFO between the MEM pipeline stage and `DataMemory`. Stores retire from MEM into the buffer in one cycle and drain to the single data-memory port whenever no load is using it. Loads to a word with a pending store are flagged so the pipeline stalls until that store has drained. Misaligned stores are rejected here and reported as AddressError.

---
 rtl/my_lib.sv | 28 ++
 rtl/sb_fifo.sv | 58 +++++
 rtl/store_buffer.sv | 95 +++++++++
 tb/tb_store_buffer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/my_lib.sv
// Shared store-buffer types: memory access grain, buffered store entry,
// and the alignment rule applied to stores before they are enqueued.
package my_lib;

    typedef enum logic [1:0] {
        MEM_WORD = 2'b00,
        MEM_BYTE = 2'b01,
        MEM_HALF = 2'b10
    } mem_grain_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  grain;
        logic [31:0] pc;
    } sb_entry_t;

    // Only the low address bits matter for alignment; grain 2'b11 is never legal.
    function automatic logic grain_aligned(input logic [1:0] addr, input logic [1:0] grain);
        case (grain)
            MEM_WORD: return (addr == 2'b00);
            MEM_HALF: return !addr[0];
            MEM_BYTE: return 1'b1;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/sb_fifo.sv
// Circular FIFO of buffered stores. Every slot's word address and occupancy
// is exposed so the owner can compare a load against all pending stores.
module sb_fifo
    import my_lib::*;
#(
    parameter int DEPTH    = 4,
    parameter int LOGDEPTH = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  sb_entry_t         push_entry,
    input  logic              pop,
    output sb_entry_t         head_entry,
    output logic [29:0]       entry_waddr [DEPTH],
    output logic [DEPTH-1:0]  entry_valid,
    output logic [LOGDEPTH:0] count,
    output logic              full,
    output logic              empty
);

    sb_entry_t             slots [DEPTH];
    logic [LOGDEPTH:0]     head;
    logic [LOGDEPTH:0]     tail;
    logic [LOGDEPTH-1:0]   offset;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (push) slots[tail[LOGDEPTH-1:0]] <= push_entry;
    end

    assign count      = tail - head;
    assign full       = (count == (LOGDEPTH+1)'(DEPTH));
    assign empty      = (count == '0);
    assign head_entry = empty ? '0 : slots[head[LOGDEPTH-1:0]];

    // A slot is live when its distance from the head is below the fill count.
    always_comb begin
        offset      = '0;
        entry_valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset         = LOGDEPTH'(i) - head[LOGDEPTH-1:0];
            entry_valid[i] = ({1'b0, offset} < count);
            entry_waddr[i] = slots[i].addr[31:2];
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Store buffer between MEM and DataMemory: rejects misaligned stores,
// drains to the shared memory port when loads leave it idle, flags load hazards.
module store_buffer
    import my_lib::*;
#(
    parameter int DEPTH    = 4,
    parameter int LOGDEPTH = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              st_valid,
    output logic              st_ready,
    input  logic [31:0]       st_addr,
    input  logic [31:0]       st_data,
    input  logic [1:0]        st_grain,
    input  logic [31:0]       st_pc,
    input  logic              ld_valid,
    input  logic [31:0]       ld_addr,
    output logic              ld_conflict,
    output logic              mem_we,
    output logic [31:0]       mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [1:0]        mem_grain,
    output logic [31:0]       mem_pc,
    output logic              empty,
    output logic [LOGDEPTH:0] count,
    output logic              addr_err,
    output logic [31:0]       err_pc
);

    sb_entry_t        push_entry;
    sb_entry_t        head_entry;
    logic [29:0]      entry_waddr [DEPTH];
    logic [DEPTH-1:0] entry_valid;
    logic [DEPTH-1:0] hit;
    logic             full;
    logic             aligned;
    logic             accept;
    logic             reject;
    logic             drain;
    logic [1:0]       unused_ld_lsb;

    assign aligned    = grain_aligned(st_addr[1:0], st_grain);
    assign st_ready   = !full;
    assign accept     = st_valid && st_ready && aligned;
    assign reject     = st_valid && st_ready && !aligned;
    assign push_entry = '{addr: st_addr, data: st_data, grain: st_grain, pc: st_pc};

    sb_fifo #(
        .DEPTH    (DEPTH),
        .LOGDEPTH (LOGDEPTH)
    ) u_fifo (
        .clock       (clock),
        .reset       (reset),
        .push        (accept),
        .push_entry  (push_entry),
        .pop         (drain),
        .head_entry  (head_entry),
        .entry_waddr (entry_waddr),
        .entry_valid (entry_valid),
        .count       (count),
        .full        (full),
        .empty       (empty)
    );

    // Loads compare at word granularity; the head still counts until its write lands.
    always_comb begin
        hit = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hit[i] = entry_valid[i] && (entry_waddr[i] == ld_addr[31:2]);
        end
    end

    assign unused_ld_lsb = ld_addr[1:0];
    assign ld_conflict   = ld_valid && (|hit);

    // A stalled (conflicting) load releases the port so the blocking store can drain.
    assign drain     = !empty && (!ld_valid || ld_conflict);
    assign mem_we    = drain;
    assign mem_addr  = head_entry.addr;
    assign mem_wdata = head_entry.data;
    assign mem_grain = head_entry.grain;
    assign mem_pc    = head_entry.pc;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            addr_err <= 1'b0;
            err_pc   <= '0;
        end else begin
            addr_err <= reject;
            if (reject) err_pc <= st_pc;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: expected drains and address errors are
// queued at stimulus time and checked by a monitor when the DUT presents them.
module tb_store_buffer;

    logic        clock;
    logic        reset;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [1:0]  st_grain;
    logic [31:0] st_pc;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic        ld_conflict;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  mem_grain;
    logic [31:0] mem_pc;
    logic        empty;
    logic [2:0]  count;
    logic        addr_err;
    logic [31:0] err_pc;

    int checks = 0;
    int errors = 0;

    logic [97:0] exp_q [$];   // {addr, data, grain, pc}
    logic [63:0] err_q [$];   // {pc, addr}

    store_buffer #(.DEPTH(4), .LOGDEPTH(2)) dut (
        .clock       (clock),
        .reset       (reset),
        .st_valid    (st_valid),
        .st_ready    (st_ready),
        .st_addr     (st_addr),
        .st_data     (st_data),
        .st_grain    (st_grain),
        .st_pc       (st_pc),
        .ld_valid    (ld_valid),
        .ld_addr     (ld_addr),
        .ld_conflict (ld_conflict),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_grain   (mem_grain),
        .mem_pc      (mem_pc),
        .empty       (empty),
        .count       (count),
        .addr_err    (addr_err),
        .err_pc      (err_pc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] g, input logic [31:0] pc);
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        st_grain = g;
        st_pc    = pc;
        tick();
        st_valid = 1'b0;
    endtask

    task automatic good_store(input logic [31:0] a, input logic [31:0] d,
                              input logic [1:0] g, input logic [31:0] pc);
        exp_q.push_back({a, d, g, pc});
        store(a, d, g, pc);
    endtask

    task automatic bad_store(input logic [31:0] a, input logic [1:0] g, input logic [31:0] pc);
        err_q.push_back({pc, a});
        store(a, 32'h0BAD_0BAD, g, pc);
        check("bad_store_count", 128'(count), 128'd0);
        tick();
        check("addr_err_one_cycle", 128'(addr_err), 128'd0);
    endtask

    // Monitor: every memory write and every address error must match the queues.
    always @(negedge clock) begin
        if (reset) begin
            if (mem_we) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_drain", 128'({mem_addr, mem_pc}), 128'd0);
                end else begin
                    check("drain_entry", 128'({mem_addr, mem_wdata, mem_grain, mem_pc}),
                          128'(exp_q.pop_front()));
                end
            end
            if (addr_err) begin
                if (err_q.size() == 0) begin
                    check("unexpected_addr_err", 128'(err_pc), 128'd0);
                end else begin
                    logic [63:0] e;
                    e = err_q.pop_front();
                    $display("@%h: *%h SignalException AddressError", e[63:32], e[31:0]);
                    check("err_pc", 128'(err_pc), 128'(e[63:32]));
                end
            end
        end
    end

    initial begin
        reset    = 1'b0;
        st_valid = 1'b0;
        st_addr  = '0;
        st_data  = '0;
        st_grain = '0;
        st_pc    = '0;
        ld_valid = 1'b0;
        ld_addr  = '0;
        #12;
        check("rst_count", 128'(count), 128'd0);
        check("rst_flags", 128'({empty, st_ready, mem_we, ld_conflict, addr_err}), 128'b11000);
        check("rst_mem_out", 128'({mem_addr, mem_wdata, mem_grain, mem_pc}), 128'd0);
        check("rst_err_pc", 128'(err_pc), 128'd0);
        reset = 1'b1;
        tick();

        // single word store drains on the following cycle
        good_store(32'h10, 32'hDEADBEEF, 2'b00, 32'h100);
        check("single_count1", 128'(count), 128'd1);
        check("single_mem_we", 128'({mem_we, mem_addr}), 128'({1'b1, 32'h10}));
        tick();
        check("single_count0", 128'(count), 128'd0);
        check("single_we_off", 128'(mem_we), 128'd0);

        // fill while a non-conflicting load holds the port
        ld_valid = 1'b1;
        ld_addr  = 32'h1000;
        good_store(32'h40, 32'h11111111, 2'b00, 32'h200);
        good_store(32'h45, 32'h00000022, 2'b01, 32'h204);
        good_store(32'h4A, 32'h00003333, 2'b10, 32'h208);
        good_store(32'h4C, 32'h44444444, 2'b00, 32'h20C);
        check("fill_count", 128'(count), 128'd4);
        check("fill_ready_we", 128'({st_ready, mem_we, ld_conflict}), 128'b000);
        ld_valid = 1'b0;
        repeat (4) tick();
        check("fill_drained", 128'(count), 128'd0);

        // pending half store hit by a load to the same word
        ld_valid = 1'b1;
        good_store(32'h22, 32'h0000BEEF, 2'b10, 32'h300);
        check("conf_pending", 128'({count, mem_we}), 128'({3'd1, 1'b0}));
        ld_addr = 32'h20;
        #1;
        check("conf_flag", 128'({ld_conflict, mem_we}), 128'b11);
        tick();
        check("conf_clear", 128'({ld_conflict, count}), 128'({1'b0, 3'd0}));
        ld_valid = 1'b0;
        ld_addr  = 32'h1000;

        // misaligned and illegal stores are rejected
        bad_store(32'h11, 2'b00, 32'h400);
        bad_store(32'h13, 2'b10, 32'h404);
        bad_store(32'h20, 2'b11, 32'h408);
        check("err_pc_held", 128'(err_pc), 128'(32'h408));

        // full buffer: store held across a drain is taken one cycle later
        ld_valid = 1'b1;
        good_store(32'h80, 32'hA0A0A0A0, 2'b00, 32'h500);
        good_store(32'h84, 32'hA1A1A1A1, 2'b00, 32'h504);
        good_store(32'h88, 32'hA2A2A2A2, 2'b00, 32'h508);
        good_store(32'h8C, 32'hA3A3A3A3, 2'b00, 32'h50C);
        check("full_count4", 128'(count), 128'd4);
        st_valid = 1'b1;
        st_addr  = 32'h90;
        st_data  = 32'hA4A4A4A4;
        st_grain = 2'b00;
        st_pc    = 32'h510;
        ld_valid = 1'b0;
        #1;
        check("full_no_ready", 128'({st_ready, mem_we}), 128'b01);
        tick();
        check("full_count3", 128'(count), 128'd3);
        ld_valid = 1'b1;
        exp_q.push_back({32'h90, 32'hA4A4A4A4, 2'b00, 32'h510});
        tick();
        st_valid = 1'b0;
        check("full_count4b", 128'(count), 128'd4);
        ld_valid = 1'b0;
        repeat (4) tick();
        check("full_drained", 128'(count), 128'd0);

        // asynchronous reset mid-drain discards everything
        ld_valid = 1'b1;
        store(32'hA0, 32'h1, 2'b00, 32'h600);
        store(32'hA4, 32'h2, 2'b00, 32'h604);
        store(32'hA8, 32'h3, 2'b00, 32'h608);
        check("ar_count3", 128'(count), 128'd3);
        ld_valid = 1'b0;
        #1;
        check("ar_we_before", 128'(mem_we), 128'd1);
        #1;
        reset = 1'b0;
        #1;
        check("ar_we_dropped", 128'({mem_we, count, empty, st_ready}), 128'({1'b0, 3'd0, 1'b1, 1'b1}));
        check("ar_mem_zero", 128'({mem_addr, mem_pc}), 128'd0);
        @(negedge clock);
        #1;
        reset = 1'b1;
        tick();
        ld_valid = 1'b1;
        good_store(32'hB0, 32'hCAFEF00D, 2'b00, 32'h700);
        check("ar_head", 128'({count, mem_addr, mem_wdata}), 128'({3'd1, 32'hB0, 32'hCAFEF00D}));
        ld_valid = 1'b0;

        for (int i = 0; i < 20 && (exp_q.size() != 0 || err_q.size() != 0); i++) tick();
        tick();
        check("exp_queue_empty", 128'(exp_q.size()), 128'd0);
        check("err_queue_empty", 128'(err_q.size()), 128'd0);
        check("final_empty", 128'({empty, count}), 128'({1'b1, 3'd0}));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
